cpu_state_dumper: RTL and testbench

CPU_STATE_DUMPER -- requirements
Module: cpu_state_dumper

---
 rtl/cpu_state_dumper_if.sv | 23 ++
 rtl/cpu_state_dumper.sv | 163 ++++++++++++++++
 tb/tb_cpu_state_dumper.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_state_dumper_if.sv
// Dump stream bundle for cpu_state_dumper: valid/ready handshake plus the
// data word and end-of-record marker. The master drives the words, the slave
// is the sink that accepts them.
interface cpu_state_dumper_if;
  logic        dump_valid_o;
  logic        dump_ready_i;
  logic [31:0] dump_data_o;
  logic        dump_last_o;

  modport master (
    output dump_valid_o,
    output dump_data_o,
    output dump_last_o,
    input  dump_ready_i
  );

  modport slave (
    input  dump_valid_o,
    input  dump_data_o,
    input  dump_last_o,
    output dump_ready_i
  );
endinterface

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: keeps cycle/stall/flush counters for a CPU and, on a
// trigger, streams one record: counter/PC snapshots, x0..x31, and (when the
// DUMP_MEM_EN macro is defined) data-memory words 0x00..0x1C.
//
// Record words are muxed combinationally from the word index, so the CPU has
// to hold RF/DM contents stable while busy_o is high.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | counting only, waiting for trigger_i
// SEND    | presenting record word idx, advancing on handshake
module cpu_state_dumper (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic [31:0]                pc_i,
  input  logic                       trigger_i,
  output logic [4:0]                 rf_addr_o,
  input  logic [31:0]                rf_data_i,
  output logic [4:0]                 dm_addr_o,
  input  logic [31:0]                dm_data_i,
  output logic                       busy_o,
  cpu_state_dumper_if.master         dump_if
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [5:0] RF_FIRST = 6'd4;
  localparam logic [5:0] RF_LAST  = 6'd35;
`ifdef DUMP_MEM_EN
  localparam logic [5:0] DM_FIRST = 6'd36;
  localparam logic [5:0] LAST_IDX = 6'd43;
`else
  localparam logic [5:0] LAST_IDX = 6'd35;
`endif

  logic [0:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] snap_cycle_q, snap_cycle_d;
  logic [31:0] snap_pc_q, snap_pc_d;
  logic [31:0] snap_stall_q, snap_stall_d;
  logic [31:0] snap_flush_q, snap_flush_d;

  logic sending;
  logic handshake;

  assign sending   = (state_q == ST_SEND);
  assign handshake = sending && dump_if.dump_ready_i;

  // Saturating event counters; they keep running while a record is sent.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (start_i && (cycle_cnt_q != 32'hFFFF_FFFF)) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Record sequencing; snapshots take pre-increment counter values and a
  // trigger during SEND (including on the last handshake) is dropped.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_cycle_d = snap_cycle_q;
    snap_pc_d    = snap_pc_q;
    snap_stall_d = snap_stall_q;
    snap_flush_d = snap_flush_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_i) begin
          state_d      = ST_SEND;
          idx_d        = 6'd0;
          snap_cycle_d = cycle_cnt_q;
          snap_pc_d    = pc_i;
          snap_stall_d = stall_cnt_q;
          snap_flush_d = flush_cnt_q;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 6'd0;
      end
    endcase
  end

  // State, counter and snapshot registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= 6'd0;
      cycle_cnt_q  <= 32'd0;
      stall_cnt_q  <= 32'd0;
      flush_cnt_q  <= 32'd0;
      snap_cycle_q <= 32'd0;
      snap_pc_q    <= 32'd0;
      snap_stall_q <= 32'd0;
      snap_flush_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cycle_cnt_q  <= cycle_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      snap_cycle_q <= snap_cycle_d;
      snap_pc_q    <= snap_pc_d;
      snap_stall_q <= snap_stall_d;
      snap_flush_q <= snap_flush_d;
    end
  end

  // RF/DM read addresses follow the word index; zero outside their windows.
  always_comb begin
    rf_addr_o = 5'd0;
    dm_addr_o = 5'd0;
    if ((idx_q >= RF_FIRST) && (idx_q <= RF_LAST)) rf_addr_o = 5'(idx_q - RF_FIRST);
`ifdef DUMP_MEM_EN
    if ((idx_q >= DM_FIRST) && (idx_q <= LAST_IDX)) dm_addr_o = {3'(idx_q - DM_FIRST), 2'b00};
`endif
  end

  // Word mux; zero whenever no record is in flight.
  always_comb begin
    dump_if.dump_data_o = 32'd0;
    if (sending) begin
      if (idx_q == 6'd0)      dump_if.dump_data_o = snap_cycle_q;
      else if (idx_q == 6'd1) dump_if.dump_data_o = snap_pc_q;
      else if (idx_q == 6'd2) dump_if.dump_data_o = snap_stall_q;
      else if (idx_q == 6'd3) dump_if.dump_data_o = snap_flush_q;
      else if (idx_q <= RF_LAST) dump_if.dump_data_o = rf_data_i;
`ifdef DUMP_MEM_EN
      else if (idx_q <= LAST_IDX) dump_if.dump_data_o = dm_data_i;
`endif
    end
  end

`ifndef DUMP_MEM_EN
  // DM read data has no consumer when memory words are left out of the record.
  logic unused_dm_data;
  assign unused_dm_data = ^dm_data_i;
`endif

  assign dump_if.dump_valid_o = sending;
  assign dump_if.dump_last_o  = sending && (idx_q == LAST_IDX);
  assign busy_o               = sending;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Directed testbench for cpu_state_dumper. Honours DUMP_MEM_EN the same way
// as the design (44-word record when defined, 36 otherwise).
module tb_cpu_state_dumper;

`ifdef DUMP_MEM_EN
  localparam int LAST = 43;
`else
  localparam int LAST = 35;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        flush;
  logic [31:0] pc;
  logic        trigger;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  dm_addr;
  logic [31:0] dm_data;
  logic        busy;

  logic [31:0] rf_m [32];
  logic [31:0] dm_m [32];

  int vectors;
  int miscompares;

  cpu_state_dumper_if dif ();

  cpu_state_dumper dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .stall_i   (stall),
    .flush_i   (flush),
    .pc_i      (pc),
    .trigger_i (trigger),
    .rf_addr_o (rf_addr),
    .rf_data_i (rf_data),
    .dm_addr_o (dm_addr),
    .dm_data_i (dm_data),
    .busy_o    (busy),
    .dump_if   (dif)
  );

  assign rf_data = rf_m[rf_addr];
  assign dm_data = dm_m[dm_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int i, input logic [31:0] c,
                                           input logic [31:0] p, input logic [31:0] s,
                                           input logic [31:0] f);
    if (i == 0) return c;
    if (i == 1) return p;
    if (i == 2) return s;
    if (i == 3) return f;
    if (i <= 35) return rf_m[5'(i - 4)];
    if (i <= 43) return dm_m[5'((i - 36) * 4)];
    return 32'd0;
  endfunction

  task automatic drain();
    dif.dump_ready_i = 1'b1;
    for (int k = 0; k < 60 && dif.dump_valid_o; k++) tick();
    vectors++;
    if (dif.dump_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: valid=%b after 60 cycles, want 0", dif.dump_valid_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if ({dif.dump_valid_o, dif.dump_last_o, busy} !== 3'b000 || dif.dump_data_o !== 32'd0 ||
        rf_addr !== 5'd0 || dm_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b last=%b busy=%b data=%h rf=%0d dm=%0d, want all 0",
               dif.dump_valid_o, dif.dump_last_o, busy, dif.dump_data_o, rf_addr, dm_addr);
    end
    trigger = 1'b1;
    start = 1'b1;
    tick();
    tick();
    vectors++;
    if (dif.dump_valid_o !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_trigger_held: valid=%b busy=%b, want 0 0", dif.dump_valid_o, busy);
    end
    trigger = 1'b0;
    start = 1'b0;
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_snapshot_and_stream();
    start = 1'b1;
    repeat (10) tick();
    start = 1'b0;
    stall = 1'b1; tick();
    stall = 1'b0; tick();
    stall = 1'b1; tick();
    stall = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    pc = 32'hCAFE_0040;
    dif.dump_ready_i = 1'b1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int n = 0; n <= LAST; n++) begin
      vectors++;
      if (dif.dump_valid_o !== 1'b1 || busy !== 1'b1 ||
          dif.dump_data_o !== exp_word(n, 32'd10, 32'hCAFE_0040, 32'd2, 32'd1) ||
          dif.dump_last_o !== (n == LAST)) begin
        miscompares++;
        $display("FAIL stream idx%0d: valid=%b busy=%b data=%h last=%b, want 1 1 %h %b", n,
                 dif.dump_valid_o, busy, dif.dump_data_o,
                 dif.dump_last_o, exp_word(n, 32'd10, 32'hCAFE_0040, 32'd2, 32'd1), n == LAST);
      end
      if (n == 9) begin
        vectors++;
        if (rf_addr !== 5'd5 || dif.dump_data_o !== 32'h1234_5678) begin
          miscompares++;
          $display("FAIL stream_x5: rf_addr=%0d data=%h, want 5 12345678", rf_addr, dif.dump_data_o);
        end
      end
`ifdef DUMP_MEM_EN
      if (n == 36) begin
        vectors++;
        if (dm_addr !== 5'd0 || dif.dump_data_o !== 32'd5) begin
          miscompares++;
          $display("FAIL stream_dm0: dm_addr=%0d data=%h, want 0 5", dm_addr, dif.dump_data_o);
        end
      end
      if (n == 43) begin
        vectors++;
        if (dm_addr !== 5'd28) begin
          miscompares++;
          $display("FAIL stream_dm_last: dm_addr=%0d, want 28", dm_addr);
        end
      end
`endif
      tick();
    end
    vectors++;
    if (dif.dump_valid_o !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_end: valid=%b busy=%b, want 0 0", dif.dump_valid_o, busy);
    end
  endtask

  task automatic test_backpressure();
    dif.dump_ready_i = 1'b1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int n = 0; n <= LAST; n++) begin
      if (n == 4) begin
        dif.dump_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
          vectors++;
          if (dif.dump_valid_o !== 1'b1 || dif.dump_data_o !== 32'h0BAD_0000 ||
              rf_addr !== 5'd0 || dif.dump_last_o !== 1'b0) begin
            miscompares++;
            $display("FAIL hold cyc%0d: valid=%b data=%h rf=%0d last=%b, want 1 0bad0000 0 0", k,
                     dif.dump_valid_o, dif.dump_data_o, rf_addr, dif.dump_last_o);
          end
          tick();
        end
        dif.dump_ready_i = 1'b1;
      end
      vectors++;
      if (dif.dump_valid_o !== 1'b1 ||
          dif.dump_data_o !== exp_word(n, 32'd10, 32'hCAFE_0040, 32'd2, 32'd1) ||
          dif.dump_last_o !== (n == LAST)) begin
        miscompares++;
        $display("FAIL backpressure idx%0d: valid=%b data=%h last=%b, want 1 %h %b", n,
                 dif.dump_valid_o, dif.dump_data_o, dif.dump_last_o,
                 exp_word(n, 32'd10, 32'hCAFE_0040, 32'd2, 32'd1), n == LAST);
      end
      tick();
    end
    vectors++;
    if (dif.dump_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_end: valid=%b, want 0", dif.dump_valid_o);
    end
  endtask

  task automatic test_trigger_ignore();
    dif.dump_ready_i = 1'b1;
    trigger = 1'b1;
    tick();
    for (int n = 0; n <= LAST; n++) begin
      trigger = (n == 20) || (n == LAST);
      vectors++;
      if (dif.dump_valid_o !== 1'b1 ||
          dif.dump_data_o !== exp_word(n, 32'd10, 32'hCAFE_0040, 32'd2, 32'd1)) begin
        miscompares++;
        $display("FAIL ignore idx%0d: valid=%b data=%h, want 1 %h", n, dif.dump_valid_o,
                 dif.dump_data_o, exp_word(n, 32'd10, 32'hCAFE_0040, 32'd2, 32'd1));
      end
      tick();
    end
    trigger = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (dif.dump_valid_o !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore_idle cyc%0d: valid=%b busy=%b, want 0 0", k, dif.dump_valid_o, busy);
      end
      tick();
    end
  endtask

  task automatic test_coincident_pulse();
    dif.dump_ready_i = 1'b1;
    flush = 1'b1;
    trigger = 1'b1;
    tick();
    flush = 1'b0;
    trigger = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (dif.dump_data_o !== 32'd1) begin
      miscompares++;
      $display("FAIL coincident_first: flush snapshot=%h, want 1", dif.dump_data_o);
    end
    drain();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (dif.dump_data_o !== 32'd2) begin
      miscompares++;
      $display("FAIL coincident_next: flush snapshot=%h, want 2", dif.dump_data_o);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    dif.dump_ready_i = 1'b1;
    start = 1'b1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (10) tick();
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({dif.dump_valid_o, busy, dif.dump_last_o} !== 3'b000 || dif.dump_data_o !== 32'd0 ||
        rf_addr !== 5'd0 || dm_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b busy=%b last=%b data=%h rf=%0d dm=%0d, want all 0",
               dif.dump_valid_o, busy, dif.dump_last_o, dif.dump_data_o, rf_addr, dm_addr);
    end
    tick();
    tick();
    #3 rst = 1'b0;
    pc = 32'h0000_0124;
    for (int k = 0; k < 7; k++) begin
      tick();
      vectors++;
      if (dif.dump_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_no_words cyc%0d: valid=%b, want 0", k, dif.dump_valid_o);
      end
    end
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      vectors++;
      if (dif.dump_valid_o !== 1'b1 ||
          dif.dump_data_o !== exp_word(n, 32'd7, 32'h0000_0124, 32'd0, 32'd0)) begin
        miscompares++;
        $display("FAIL reset_restart idx%0d: valid=%b data=%h, want 1 %h", n, dif.dump_valid_o,
                 dif.dump_data_o, exp_word(n, 32'd7, 32'h0000_0124, 32'd0, 32'd0));
      end
      tick();
    end
    drain();
  endtask

  task automatic test_saturate();
    #3;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    for (int k = 0; k < 3; k++) begin
      tick();
      stall = 1'b1;
      tick();
      stall = 1'b0;
    end
    dif.dump_ready_i = 1'b1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    tick();
    vectors++;
    if (dif.dump_data_o !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL saturate: stall snapshot=%h, want ffffffff", dif.dump_data_o);
    end
    tick();
    vectors++;
    if (dif.dump_data_o !== 32'd0) begin
      miscompares++;
      $display("FAIL saturate_flush: flush snapshot=%h, want 0", dif.dump_data_o);
    end
    drain();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    pc          = 32'd0;
    trigger     = 1'b0;
    dif.dump_ready_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf_m[i] = 32'hA000_0000 + 32'(i);
      dm_m[i] = 32'hD000_0000 + 32'(i);
    end
    rf_m[0] = 32'h0BAD_0000;
    rf_m[5] = 32'h1234_5678;
    dm_m[0] = 32'd5;

    test_reset();
    test_snapshot_and_stream();
    test_backpressure();
    test_trigger_ignore();
    test_coincident_pulse();
    test_reset_mid();
    test_saturate();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
